vram_scanout: RTL

- Sits directly upstream of the single-port synchronous RAM (1-cycle registered read, write on we at posedge) and is its only master.
- Prefetches a 1bpp 32x32-byte bitmap in step with the video beam (hpos/vpos from the sync generator) and serializes it to a pixel stream.
- Arbitrates CPU read/write access into the remaining RAM cycles with a req/ack handshake.

---
 rtl/vram_scanout_pkg.sv | 14 +
 rtl/vram_scanout_if.sv | 21 ++
 rtl/vram_pixel_shifter.sv | 24 ++
 rtl/vram_scanout.sv | 59 +++++
 4 files changed

// File: rtl/vram_scanout_pkg.sv
// vram_scanout_pkg: address-field widths, beam slot phases, slot kinds and the next-line row helper
package vram_scanout_pkg;
  localparam int COL_BITS = 5;
  localparam int ROW_BITS = 5;
  localparam logic [2:0] FETCH_PHASE = 3'd5;
  localparam logic [2:0] LOAD_PHASE = 3'd7;
  localparam int LINE_FETCH_OFS = 3;
  typedef enum logic [1:0] {SLOT_IDLE, SLOT_CPU, SLOT_GROUP, SLOT_LINE} slot_e;
  function automatic logic [ROW_BITS-1:0] next_row(input logic [8:0] v, input int vtotal);
    logic [8:0] n;
    n = (v == 9'(vtotal - 1)) ? 9'd0 : v + 9'd1;
    return n[3 +: ROW_BITS];
  endfunction
endpackage

// File: rtl/vram_scanout_if.sv
// vram_scanout_if: cpu req/ack bus (master=cpu, slave=scanout) and vram_ram_if single-port RAM bus (master=scanout, slave=ram)
interface vram_scanout_if #(parameter int A = 10, parameter int D = 8);
  logic req;
  logic we;
  logic [A-1:0] addr;
  logic [D-1:0] wdata;
  logic ack;
  logic [D-1:0] rdata;
  logic rvalid;
  modport master(output req, we, addr, wdata, input ack, rdata, rvalid);
  modport slave(input req, we, addr, wdata, output ack, rdata, rvalid);
endinterface

interface vram_ram_if #(parameter int A = 10, parameter int D = 8);
  logic [A-1:0] addr;
  logic [D-1:0] din;
  logic we;
  logic [D-1:0] dout;
  modport master(output addr, din, we, input dout);
  modport slave(input addr, din, we, output dout);
endinterface

// File: rtl/vram_pixel_shifter.sv
// vram_pixel_shifter: holding register captures fetched byte, shifter loads it on load else shifts left; ports clk/reset, capture, load, din, msb
module vram_pixel_shifter #(
  parameter int D = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic capture,
  input  logic load,
  input  logic [D-1:0] din,
  output logic msb
);
  logic [D-1:0] hold;
  logic [D-1:0] shift;
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      shift <= '0;
    end else begin
      if (capture) hold <= din;
      shift <= load ? hold : {shift[D-2:0], 1'b0};
    end
  end
  assign msb = shift[D-1];
endmodule

// File: rtl/vram_scanout.sv
// vram_scanout: beam-locked 1bpp bitmap prefetch with CPU arbitration into free RAM cycles; ports clk/reset, hpos/vpos/display_on, ram (RAM master), cpu (req/ack slave), pixel
module vram_scanout
  import vram_scanout_pkg::*;
#(
  parameter int A = 10,
  parameter int D = 8,
  parameter int HTOTAL = 309,
  parameter int VTOTAL = 262
) (
  input  logic clk,
  input  logic reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic display_on,
  vram_ram_if.master ram,
  vram_scanout_if.slave cpu,
  output logic pixel
);
  slot_e slot;
  logic group_slot, line_slot, load, fetch_now, fetch_d, cpu_rd_d, shift_msb;
  logic [COL_BITS-1:0] col;
  assign col = hpos[3 +: COL_BITS];
  // group fetch grabs the next column's byte three cycles before it is needed; column 31 has no successor
  assign group_slot = !hpos[8] && col != '1 && hpos[2:0] == FETCH_PHASE;
  assign line_slot = hpos == 9'(HTOTAL - LINE_FETCH_OFS);
  assign load = (!hpos[8] && hpos[2:0] == LOAD_PHASE) || hpos == 9'(HTOTAL - 1);
  always_comb begin
    slot = line_slot ? SLOT_LINE : group_slot ? SLOT_GROUP : (cpu.req && !reset) ? SLOT_CPU : SLOT_IDLE;
    fetch_now = slot == SLOT_GROUP || slot == SLOT_LINE;
    ram.addr = slot == SLOT_LINE ? {next_row(vpos, VTOTAL), COL_BITS'(0)}
             : slot == SLOT_GROUP ? {vpos[3 +: ROW_BITS], col + COL_BITS'(1)}
             : cpu.addr;
    ram.din = cpu.wdata;
    ram.we = slot == SLOT_CPU && cpu.we;
    cpu.ack = slot == SLOT_CPU;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_d <= 1'b0;
      cpu_rd_d <= 1'b0;
      cpu.rvalid <= 1'b0;
      cpu.rdata <= '0;
    end else begin
      fetch_d <= fetch_now;
      cpu_rd_d <= cpu.ack && !cpu.we;
      cpu.rvalid <= cpu_rd_d;
      if (cpu_rd_d) cpu.rdata <= ram.dout;
    end
  end
  vram_pixel_shifter #(.D(D)) u_shifter (
    .clk(clk),
    .reset(reset),
    .capture(fetch_d),
    .load(load),
    .din(ram.dout),
    .msb(shift_msb)
  );
  assign pixel = shift_msb & display_on;
endmodule
